// File: rtl/game_pkg.sv
// Shared definitions for the typing-race game controller: state encoding,
// PS/2 scancodes of the control keys and the round-length preset tables.
package game_pkg;

  typedef enum logic [1:0] {
    SELECT    = 2'd0,
    COUNTDOWN = 2'd1,
    INGAME    = 2'd2,
    FINISH    = 2'd3
  } game_state_t;

  localparam logic [6:0] KEY_ENTER = 7'h5A;
  localparam logic [6:0] KEY_ESC   = 7'h76;
  localparam logic [6:0] KEY_M     = 7'h3A;
  localparam logic [6:0] KEY_V     = 7'h2A;

  // Seconds for a timed round, words for a word-count round.
  localparam logic [6:0] TIME_PRESET [4] = '{7'd15, 7'd30, 7'd60, 7'd120};
  localparam logic [6:0] WORD_PRESET [4] = '{7'd10, 7'd25, 7'd50, 7'd100};

  function automatic logic [6:0] preset_value(input logic mode, input logic [1:0] sel);
    return mode ? WORD_PRESET[sel] : TIME_PRESET[sel];
  endfunction

endpackage

// File: rtl/game_sequencer_key_press_edge.sv
// key_press_edge: turns the keyboard decoder's held flags plus event strobe
// into a single-cycle press for a freshly pressed key. Breaks and typematic
// repeats of a key that is already held produce no press.
module key_press_edge
  import game_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  output logic         press,
  output logic [6:0]   press_code
);

  logic held;
  logic prev_held;
  logic unused_bits;

  assign held        = key_down[last_change[6:0]];
  assign unused_bits = ^last_change[8:7];

  // Remember whether the key named by last_change was already held last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_held <= 1'b0;
    else        prev_held <= held;
  end

  assign press      = key_valid && held && !prev_held;
  assign press_code = last_change[6:0];

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game FSM. Selects mode and length in SELECT,
// runs an optional 3-second countdown, then hands control to the datapath
// until it reports finish or the player aborts with ESC.
// Optional feature macro: GAME_COUNTDOWN_EN (countdown state, prescaler and
// cd_digit). Without it ENTER jumps straight from SELECT to INGAME.
// The key event input is a plain strobe (key_valid, no ready): a press is
// observed in the cycle key_valid is high and acted upon at the next edge.
module game_sequencer
  import game_pkg::*;
#(
  parameter int CYC_PER_SEC = 100_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key_down,
  input  logic [8:0]   last_change,
  input  logic         key_valid,
  input  logic         finish,
  output logic [1:0]   state,
  output logic         mode,
  output logic [6:0]   value,
  output logic [1:0]   cd_digit,
  output logic         start_pulse,
  output logic         done_pulse
);

  game_state_t cur_state, next_state;
  logic        press;
  logic [6:0]  press_code;
  logic        is_enter, is_esc, is_m, is_v;
  logic [1:0]  sel, sel_n;
  logic        mode_n;

  key_press_edge u_key_press_edge (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .press       (press),
    .press_code  (press_code)
  );

  assign is_enter = press && (press_code == KEY_ENTER);
  assign is_esc   = press && (press_code == KEY_ESC);
  assign is_m     = press && (press_code == KEY_M);
  assign is_v     = press && (press_code == KEY_V);

  assign state = cur_state;

`ifdef GAME_COUNTDOWN_EN
  localparam int PW = (CYC_PER_SEC > 1) ? $clog2(CYC_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CYC_PER_SEC - 1);
  logic [PW-1:0] prescaler;
  logic          cd_wrap;
  assign cd_wrap = (prescaler == PRE_MAX);
`else
  logic unused_cfg;
  assign unused_cfg = (CYC_PER_SEC > 0);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= SELECT;
    else        cur_state <= next_state;
  end

  // Next-state logic; ESC is checked first wherever it has an effect.
  always_comb begin
    next_state = cur_state;
    case (cur_state)
      SELECT: begin
        if (is_enter) begin
`ifdef GAME_COUNTDOWN_EN
          next_state = COUNTDOWN;
`else
          next_state = INGAME;
`endif
        end
      end
      COUNTDOWN: begin
`ifdef GAME_COUNTDOWN_EN
        if (is_esc)                            next_state = SELECT;
        else if (cd_wrap && cd_digit == 2'd1) next_state = INGAME;
`else
        next_state = SELECT;
`endif
      end
      INGAME: begin
        if (is_esc)      next_state = SELECT;
        else if (finish) next_state = FINISH;
      end
      FINISH: begin
        if (is_esc || is_enter) next_state = SELECT;
      end
      default: next_state = SELECT;
    endcase
  end

  // Selection edits: M and V only act while in SELECT.
  always_comb begin
    mode_n = mode;
    sel_n  = sel;
    if (cur_state == SELECT) begin
      if (is_m) mode_n = ~mode;
      if (is_v) sel_n  = sel + 2'd1;
    end
  end

  // Registered outputs: selection, preset value and entry pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode        <= 1'b0;
      sel         <= 2'd0;
      value       <= TIME_PRESET[0];
      start_pulse <= 1'b0;
      done_pulse  <= 1'b0;
    end else begin
      mode        <= mode_n;
      sel         <= sel_n;
      value       <= preset_value(mode_n, sel_n);
      start_pulse <= (next_state == INGAME) && (cur_state != INGAME);
      done_pulse  <= (next_state == FINISH) && (cur_state != FINISH);
    end
  end

`ifdef GAME_COUNTDOWN_EN
  // Countdown prescaler and digit: restart on entry, tick down on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      cd_digit  <= 2'd0;
    end else if (next_state == COUNTDOWN && cur_state != COUNTDOWN) begin
      prescaler <= '0;
      cd_digit  <= 2'd3;
    end else if (next_state == COUNTDOWN) begin
      if (cd_wrap) begin
        prescaler <= '0;
        cd_digit  <= cd_digit - 2'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end else begin
      prescaler <= '0;
      cd_digit  <= 2'd0;
    end
  end
`else
  assign cd_digit = 2'd0;
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: a cycle-level behavioural model of the game
// rules is compared with the DUT on every falling edge, and directed key
// sequences add hand-computed literal checks. Countdown-specific sequences
// are compiled only when GAME_COUNTDOWN_EN is defined.
module tb_game_sequencer;

  localparam int CYC = 10;
  localparam logic [6:0] K_ENTER = 7'h5A;
  localparam logic [6:0] K_ESC   = 7'h76;
  localparam logic [6:0] K_M     = 7'h3A;
  localparam logic [6:0] K_V     = 7'h2A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] key_down = '0;
  logic [8:0]   last_change = '0;
  logic         key_valid = 1'b0;
  logic         finish = 1'b0;
  logic [1:0]   state;
  logic         mode;
  logic [6:0]   value;
  logic [1:0]   cd_digit;
  logic         start_pulse;
  logic         done_pulse;

  int errors = 0;
  int checks = 0;

  game_sequencer #(.CYC_PER_SEC(CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .finish      (finish),
    .state       (state),
    .mode        (mode),
    .value       (value),
    .cd_digit    (cd_digit),
    .start_pulse (start_pulse),
    .done_pulse  (done_pulse)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int time_tab[4] = '{15, 30, 60, 120};
  int word_tab[4] = '{10, 25, 50, 100};

  int m_state = 0;    // 0 select, 1 countdown, 2 ingame, 3 finish
  int m_mode  = 0;
  int m_sel   = 0;
  int m_el    = 0;    // cycles elapsed since countdown entry
  bit m_prev  = 1'b0;
  bit m_start = 1'b0;
  bit m_done  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_mode = 0; m_sel = 0; m_el = 0;
      m_prev = 1'b0; m_start = 1'b0; m_done = 1'b0;
    end else begin
      int  old;
      bit  pr;
      logic [6:0] code;
      code   = last_change[6:0];
      pr     = key_valid && key_down[code] && !m_prev;
      m_prev = key_down[code];
      old    = m_state;
      case (m_state)
        0: begin
          if (pr && code == K_M)          m_mode = 1 - m_mode;
          else if (pr && code == K_V)     m_sel = (m_sel + 1) % 4;
          else if (pr && code == K_ENTER) begin
`ifdef GAME_COUNTDOWN_EN
            m_state = 1; m_el = 0;
`else
            m_state = 2;
`endif
          end
        end
        1: begin
          if (pr && code == K_ESC) m_state = 0;
          else begin
            m_el++;
            if (m_el == 3 * CYC) m_state = 2;
          end
        end
        2: begin
          if (pr && code == K_ESC) m_state = 0;
          else if (finish)         m_state = 3;
        end
        default: begin
          if (pr && (code == K_ESC || code == K_ENTER)) m_state = 0;
        end
      endcase
      m_start = (m_state == 2) && (old != 2);
      m_done  = (m_state == 3) && (old != 3);
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    int ev, ec;
    ev = (m_mode == 1) ? word_tab[m_sel] : time_tab[m_sel];
    ec = (m_state == 1) ? (3 - m_el / CYC) : 0;
    check("model_state", state, m_state);
    check("model_mode", mode, m_mode);
    check("model_value", value, ev);
    check("model_cd_digit", cd_digit, ec);
    check("model_start_pulse", start_pulse, m_start);
    check("model_done_pulse", done_pulse, m_done);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Make strobe, hold, break strobe, idle.
  task automatic tap(input logic [6:0] c);
    key_down[c] = 1'b1; last_change = {2'b00, c}; key_valid = 1'b1; step();
    key_valid = 1'b0; step();
    key_down[c] = 1'b0; key_valid = 1'b1; step();
    key_valid = 1'b0; step();
  endtask

  // Bounded wait for a countdown digit; expiry counts as a failure.
  task automatic wait_cd(input logic [1:0] d, input int budget);
    int n;
    n = 0;
    while (cd_digit !== d && n < budget) begin
      step();
      n++;
    end
    check("wait_cd_reached", cd_digit, d);
  endtask

  // Press ENTER in SELECT and follow the round start with literal checks.
  task automatic start_round();
    key_down[K_ENTER] = 1'b1; last_change = {2'b00, K_ENTER}; key_valid = 1'b1; step();
    key_valid = 1'b0;
`ifdef GAME_COUNTDOWN_EN
    check("cd_entry_state", state, 1);
    check("cd_entry_digit", cd_digit, 3);
    repeat (CYC - 1) step();
    check("cd_digit3_last", cd_digit, 3);
    step();
    check("cd_digit2", cd_digit, 2);
    repeat (CYC) step();
    check("cd_digit1", cd_digit, 1);
    repeat (CYC - 1) step();
    check("cd_still_counting", state, 1);
    step();
`endif
    check("ingame_state", state, 2);
    check("ingame_start_pulse", start_pulse, 1);
    check("ingame_cd_zero", cd_digit, 0);
    key_down[K_ENTER] = 1'b0; step();
    check("start_pulse_single", start_pulse, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset_state", state, 0);
    check("reset_mode", mode, 0);
    check("reset_value", value, 15);
    check("reset_cd", cd_digit, 0);
    check("reset_start", start_pulse, 0);
    check("reset_done", done_pulse, 0);
    rst_n = 1'b1;
    step();

    // Selection: M, V, V -> word mode, index 2
    tap(K_M); tap(K_V); tap(K_V);
    check("sel_mode1", mode, 1);
    check("sel_value50", value, 50);
    tap(K_V); tap(K_V);
    check("sel_wrap_value10", value, 10);
    tap(K_M);
    check("sel_mode0", mode, 0);
    check("sel_value15", value, 15);
    tap(K_ESC);
    check("esc_in_select", state, 0);

    // Held M with a repeated strobe toggles once
    key_down[K_M] = 1'b1; last_change = {2'b00, K_M}; key_valid = 1'b1; step();
    key_valid = 1'b0; step(); step();
    key_valid = 1'b1; step();
    key_valid = 1'b0; step();
    check("hold_m_once_mode", mode, 1);
    check("hold_m_once_value", value, 10);
    key_down[K_M] = 1'b0; key_valid = 1'b1; step();
    key_valid = 1'b0; step();

    // Round, ignored keys, finish, return to select
    start_round();
    tap(K_M); tap(K_V);
    check("ingame_keys_ignored_mode", mode, 1);
    check("ingame_keys_ignored_state", state, 2);
    finish = 1'b1; step();
    finish = 1'b0;
    check("finish_state", state, 3);
    check("finish_done_pulse", done_pulse, 1);
    step();
    check("done_pulse_single", done_pulse, 0);
    check("finish_hold", state, 3);
    tap(K_ENTER);
    check("finish_to_select", state, 0);
    check("finish_value_kept", value, 10);

`ifdef GAME_COUNTDOWN_EN
    // ESC during countdown
    key_down[K_ENTER] = 1'b1; last_change = {2'b00, K_ENTER}; key_valid = 1'b1; step();
    key_valid = 1'b0; key_down[K_ENTER] = 1'b0;
    wait_cd(2'd2, 4 * CYC);
    key_down[K_ESC] = 1'b1; last_change = {2'b00, K_ESC}; key_valid = 1'b1; step();
    key_valid = 1'b0;
    check("cd_esc_state", state, 0);
    check("cd_esc_digit", cd_digit, 0);
    key_down[K_ESC] = 1'b0; step(); step();
`endif

    // ESC and finish together in INGAME
    start_round();
    key_down[K_ESC] = 1'b1; last_change = {2'b00, K_ESC}; key_valid = 1'b1; finish = 1'b1; step();
    key_valid = 1'b0; finish = 1'b0;
    check("esc_beats_finish_state", state, 0);
    check("esc_beats_finish_done", done_pulse, 0);
    step();
    check("esc_beats_finish_done2", done_pulse, 0);
    key_down[K_ESC] = 1'b0; step();

    // Asynchronous reset mid-round
    start_round();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_state", state, 0);
    check("async_reset_mode", mode, 0);
    check("async_reset_value", value, 15);
    check("async_reset_cd", cd_digit, 0);
    step();
    rst_n = 1'b1;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game controller for the typing-race design. Owns the 2-bit game state consumed by the scoring/counting datapath and the display. It turns PS/2 key events into mode and length selection, runs a 3-second start countdown, and returns to selection when the datapath reports `finish` or the player aborts. The datapath, display mux and dictionary all read `state`, `mode` and `value` from this block.

## Interface
- `CYC_PER_SEC`, default 100_000_000: clock cycles per countdown second (benches use 10).
- `clk`  in  1: system clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_down`  in  128: per-scancode held flags from the keyboard decoder.
- `last_change`  in  9: scancode of the most recent make/break event; bits [6:0] are used.
- `key_valid`  in  1: one-cycle strobe marking a new `last_change`.
- `finish`  in  1: end-of-round flag from the counting datapath.
- `state`  out  2: SELECT=0, COUNTDOWN=1, INGAME=2, FINISH=3.
- `mode`  out  1: 0 = timed round, 1 = word-count round.
- `value`  out  7: seconds (mode 0) or words (mode 1).
- `cd_digit`  out  2: countdown digit 3/2/1; 0 outside COUNTDOWN.
- `start_pulse`  out  1: one cycle on entry to INGAME.
- `done_pulse`  out  1: one cycle on entry to FINISH.

## Operation
- A key press is `key_valid && key_down[last_change[6:0]]` while the internal previous-held register is clear. The register is updated every cycle from `key_down[last_change[6:0]]`. Breaks and auto-repeat are ignored.
- Scancodes: ENTER 0x5A, ESC 0x76, M 0x3A, V 0x2A.
- Preset tables, indexed by 2-bit `sel`:
  - mode 0: 15, 30, 60, 120.
  - mode 1: 10, 25, 50, 100.
  - `value = table[mode][sel]`, registered.
- SELECT:
  - M toggles `mode`; `sel` is kept.
  - V sets `sel = sel+1`, wrapping 3→0.
  - ENTER goes to COUNTDOWN, or to INGAME when the feature is compiled out.
  - ESC does nothing.
- COUNTDOWN:
  - A prescaler counts 0..CYC_PER_SEC-1. On each wrap, `cd_digit` decrements.
  - When it wraps on `cd_digit`=1, the state goes to INGAME.
  - ESC goes to SELECT.
  - `mode` and `value` are frozen.
- INGAME:
  - `finish`=1 goes to FINISH.
  - ESC goes to SELECT; ESC wins over `finish` in the same cycle.
  - Keys M and V are ignored.
- FINISH: ENTER or ESC goes to SELECT. `mode`, `value` and `sel` are retained.
- Simultaneous events: at most one press per cycle is possible by construction. ESC has the highest priority in every state.

## Timing
- Reset values: `state`=SELECT, `mode`=0, `sel`=0, `value`=15, `cd_digit`=0, both pulses 0, prescaler 0, previous-held register 0.
- Every output is a register. Each transition takes effect on the clock edge after the qualifying press or `finish` cycle (1-cycle latency).
- Entry to COUNTDOWN sets `cd_digit`=3 and prescaler=0.
- COUNTDOWN lasts exactly 3×CYC_PER_SEC cycles from entry to INGAME.
- `start_pulse` is high in the first INGAME cycle. `done_pulse` is high in the first FINISH cycle.
- Reset mid-round returns everything to reset values immediately (asynchronous). There is no partial state.
- M or V pressed in the same cycle as ENTER cannot occur; a held key that has already been counted is not re-counted.

## Configuration
- `GAME_COUNTDOWN_EN` defined:
  - The COUNTDOWN state, prescaler and `cd_digit` logic are present.
  - ENTER in SELECT goes to COUNTDOWN.
- `GAME_COUNTDOWN_EN` undefined:
  - The prescaler is removed and `cd_digit` is tied to 0.
  - ENTER in SELECT goes directly to INGAME, with `start_pulse` on the next cycle.
  - Encoding 1 is unreachable.

## Structure
- Package `game_pkg`:
  - state encodings SELECT/COUNTDOWN/INGAME/FINISH;
  - scancode constants KEY_ENTER, KEY_ESC, KEY_M, KEY_V;
  - preset tables TIME_PRESET[4], WORD_PRESET[4].
- Sub-module `key_press_edge`:
  - inputs `clk`, `rst_n`, `key_down`, `last_change`, `key_valid`;
  - outputs `press` and `press_code[6:0]`.
- The FSM, the prescaler and the preset registers stay in `game_sequencer`.

## Test plan
- Reset, then ENTER → COUNTDOWN, `cd_digit` 3 on the next cycle. With CYC_PER_SEC=10, `cd_digit` is 2 after 10 cycles and 1 after 20. INGAME with `start_pulse`=1 comes 30 cycles after entry.
- In SELECT: M, V, V → `mode`=1, `value`=50. Then V, V → `value`=10 (index wraps to 0). Then M → `value`=15.
- INGAME with `finish`=1 for one cycle → FINISH next cycle, `done_pulse` 1 for exactly one cycle. ENTER → SELECT with `value` unchanged.
- Hold M (`key_valid` strobed twice, `key_down` stays 1) → `mode` toggles once only.
- ESC during COUNTDOWN at `cd_digit`=2 → SELECT, `cd_digit`=0. ESC and `finish` in the same INGAME cycle → SELECT, no `done_pulse`.
- Deassert `rst_n` mid-INGAME → `state`=0, `mode`=0, `value`=15 with no clock edge. With `GAME_COUNTDOWN_EN` undefined, ENTER → `state`=2 next cycle.
